int_status_latch: RTL and testbench



---
 rtl/int_status_latch.sv | 118 +++++++++++
 tb/tb_int_status_latch.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/int_status_latch.sv
// int_status_latch
//   Turns rising edges on NSRC interrupt sources into per-source pending bits.
//   A CPU-written mask gates which edges are captured. The block raises one
//   prioritised request (irq/irq_vec) and holds it until the CPU acks it.
//   A single register write port does two things at once: it loads the mask
//   and clears pending bits (write one to clear).
//
// Ports
//   clk      system clock; all state changes on the rising edge
//   reset    synchronous reset, active high; overrides every other input
//   src      interrupt source levels, synchronous to clk
//   wr_en    one-cycle register write strobe
//   wr_data  [NSRC-1:0]      = new mask
//            [2*NSRC-1:NSRC] = clear-pending bits (1 = clear)
//   rd_data  registered {mask, pending}; pending is in the low NSRC bits
//   irq      registered interrupt request to the CPU
//   irq_vec  index of the serviced source; valid and stable while irq=1
//   ack      one-cycle CPU acknowledge; only acts while the request is up

// One pending bit. If set and clear arrive in the same cycle, set wins, so an
// edge that lands together with its own clear is not lost.
module int_pend_bit (
    input  logic clk,
    input  logic reset,
    input  logic set,
    input  logic clr,
    output logic q
);
    always_ff @(posedge clk) begin
        if (reset)    q <= 1'b0;
        else if (set) q <= 1'b1;
        else if (clr) q <= 1'b0;
    end
endmodule

module int_status_latch #(
    parameter int NSRC = 5,
    parameter int VW   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NSRC-1:0]   src,
    input  logic              wr_en,
    input  logic [2*NSRC-1:0] wr_data,
    output logic [2*NSRC-1:0] rd_data,
    output logic              irq,
    output logic [VW-1:0]     irq_vec,
    input  logic              ack
);
    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t            state, state_n;
    logic [NSRC-1:0]   src_q, mask, pending, active, edge_det;
    logic [VW-1:0]     first_idx;
    logic              ack_take;

    // An edge is captured with the mask that was in force before this edge.
    // A mask written in the same cycle only affects later edges.
    assign edge_det = src & ~src_q;
    assign active   = pending & mask;
    assign rd_data  = {mask, pending};

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q <= '0;
            mask  <= '0;
        end else begin
            src_q <= src;
            if (wr_en) mask <= wr_data[NSRC-1:0];
        end
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_pend
        int_pend_bit u_pend (
            .clk   (clk),
            .reset (reset),
            .set   (edge_det[i] & mask[i]),
            .clr   ((wr_en & wr_data[NSRC+i]) | (ack_take && irq_vec == VW'(i))),
            .q     (pending[i])
        );
    end

    // Lowest active index wins. Scanning downward lets the last hit stand.
    always_comb begin
        first_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (active[i]) first_idx = VW'(i);
    end

    always_comb begin
        state_n  = state;
        ack_take = 1'b0;
        case (state)
            IDLE: if (active != '0) state_n = REQ;
            // Mask changes and W1C do not retract a raised request.
            // Only ack ends it.
            REQ:  if (ack) begin
                      ack_take = 1'b1;
                      state_n  = GAP;
                  end
            GAP:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            irq     <= 1'b0;
            irq_vec <= '0;
        end else begin
            state <= state_n;
            irq   <= (state_n == REQ);
            // irq_vec is frozen for as long as the request is up.
            if (state == IDLE && active != '0) irq_vec <= first_idx;
        end
    end
endmodule

// File: tb/tb_int_status_latch.sv
module tb_int_status_latch;
    localparam int NSRC = 5;
    localparam int VW   = 3;
    localparam int NV   = 40;

    logic              clk = 1'b0;
    logic              reset;
    logic [NSRC-1:0]   src;
    logic              wr_en;
    logic [2*NSRC-1:0] wr_data;
    logic [2*NSRC-1:0] rd_data;
    logic              irq;
    logic [VW-1:0]     irq_vec;
    logic              ack;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    int_status_latch #(.NSRC(NSRC), .VW(VW)) dut (
        .clk(clk), .reset(reset), .src(src), .wr_en(wr_en), .wr_data(wr_data),
        .rd_data(rd_data), .irq(irq), .irq_vec(irq_vec), .ack(ack)
    );

    typedef struct {
        logic       rst;
        logic [4:0] src;
        logic       we;
        logic [4:0] clr;
        logic [4:0] mw;
        logic       ack;
        logic [4:0] emask;
        logic [4:0] epend;
        logic       eirq;
        logic [2:0] evec;
    } vec_t;

    vec_t tbl [NV];

    function automatic vec_t mk(logic r, logic [4:0] s, logic we, logic [4:0] clr,
                                logic [4:0] mw, logic a, logic [4:0] em, logic [4:0] ep,
                                logic ei, logic [2:0] ev);
        vec_t v;
        v.rst = r; v.src = s; v.we = we; v.clr = clr; v.mw = mw; v.ack = a;
        v.emask = em; v.epend = ep; v.eirq = ei; v.evec = ev;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs, take one rising edge, then sample 1 ns after it.
    task automatic step(logic r, logic [4:0] s, logic we, logic [4:0] clr,
                        logic [4:0] mw, logic a);
        reset = r; src = s; wr_en = we; wr_data = {clr, mw}; ack = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        reset = 1'b1; src = '1; wr_en = 1'b0; wr_data = '0; ack = 1'b0;

        // rst src we clr mw ack | mask pend irq vec
        tbl[0]  = mk(1, 5'h1F, 0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 0, 0);
        tbl[1]  = mk(1, 5'h1F, 0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 0, 0);
        tbl[2]  = mk(0, 5'h1F, 0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 0, 0);
        tbl[3]  = mk(0, 5'h00, 0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 0, 0);
        tbl[4]  = mk(0, 5'h04, 0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 0, 0);
        tbl[5]  = mk(0, 5'h00, 1, 5'h00, 5'h04, 0, 5'h04, 5'h00, 0, 0);
        tbl[6]  = mk(0, 5'h04, 0, 5'h00, 5'h00, 0, 5'h04, 5'h04, 0, 0);
        tbl[7]  = mk(0, 5'h00, 0, 5'h00, 5'h00, 0, 5'h04, 5'h04, 1, 2);
        tbl[8]  = mk(0, 5'h00, 0, 5'h00, 5'h00, 1, 5'h04, 5'h00, 0, 0);
        tbl[9]  = mk(0, 5'h00, 0, 5'h00, 5'h00, 0, 5'h04, 5'h00, 0, 0);
        tbl[10] = mk(0, 5'h00, 1, 5'h00, 5'h1F, 0, 5'h1F, 5'h00, 0, 0);
        tbl[11] = mk(0, 5'h0A, 0, 5'h00, 5'h00, 0, 5'h1F, 5'h0A, 0, 0);
        tbl[12] = mk(0, 5'h0A, 0, 5'h00, 5'h00, 0, 5'h1F, 5'h0A, 1, 1);
        tbl[13] = mk(0, 5'h00, 0, 5'h00, 5'h00, 1, 5'h1F, 5'h08, 0, 0);
        tbl[14] = mk(0, 5'h00, 0, 5'h00, 5'h00, 0, 5'h1F, 5'h08, 0, 0);
        tbl[15] = mk(0, 5'h00, 0, 5'h00, 5'h00, 0, 5'h1F, 5'h08, 1, 3);
        tbl[16] = mk(0, 5'h00, 0, 5'h00, 5'h00, 1, 5'h1F, 5'h00, 0, 0);
        tbl[17] = mk(0, 5'h00, 0, 5'h00, 5'h00, 1, 5'h1F, 5'h00, 0, 0);
        tbl[18] = mk(0, 5'h01, 1, 5'h01, 5'h1F, 0, 5'h1F, 5'h01, 0, 0);
        tbl[19] = mk(0, 5'h01, 0, 5'h00, 5'h00, 0, 5'h1F, 5'h01, 1, 0);
        tbl[20] = mk(0, 5'h00, 0, 5'h00, 5'h00, 1, 5'h1F, 5'h00, 0, 0);
        tbl[21] = mk(0, 5'h00, 0, 5'h00, 5'h00, 0, 5'h1F, 5'h00, 0, 0);
        tbl[22] = mk(0, 5'h10, 0, 5'h00, 5'h00, 0, 5'h1F, 5'h10, 0, 0);
        tbl[23] = mk(0, 5'h00, 0, 5'h00, 5'h00, 0, 5'h1F, 5'h10, 1, 4);
        tbl[24] = mk(0, 5'h00, 1, 5'h00, 5'h00, 0, 5'h00, 5'h10, 1, 4);
        tbl[25] = mk(0, 5'h00, 0, 5'h00, 5'h00, 1, 5'h00, 5'h00, 0, 0);
        tbl[26] = mk(0, 5'h00, 0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 0, 0);
        tbl[27] = mk(0, 5'h00, 0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 0, 0);
        tbl[28] = mk(0, 5'h00, 1, 5'h00, 5'h1F, 0, 5'h1F, 5'h00, 0, 0);
        tbl[29] = mk(0, 5'h04, 0, 5'h00, 5'h00, 0, 5'h1F, 5'h04, 0, 0);
        tbl[30] = mk(0, 5'h00, 1, 5'h04, 5'h1F, 0, 5'h1F, 5'h00, 1, 2);
        tbl[31] = mk(0, 5'h00, 0, 5'h00, 5'h00, 0, 5'h1F, 5'h00, 1, 2);
        tbl[32] = mk(0, 5'h00, 0, 5'h00, 5'h00, 1, 5'h1F, 5'h00, 0, 0);
        tbl[33] = mk(0, 5'h00, 0, 5'h00, 5'h00, 0, 5'h1F, 5'h00, 0, 0);
        tbl[34] = mk(0, 5'h00, 0, 5'h00, 5'h00, 0, 5'h1F, 5'h00, 0, 0);
        tbl[35] = mk(0, 5'h02, 0, 5'h00, 5'h00, 0, 5'h1F, 5'h02, 0, 0);
        tbl[36] = mk(0, 5'h00, 0, 5'h00, 5'h00, 0, 5'h1F, 5'h02, 1, 1);
        tbl[37] = mk(1, 5'h00, 0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 0, 0);
        tbl[38] = mk(0, 5'h00, 0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 0, 0);
        tbl[39] = mk(0, 5'h00, 0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 0, 0);

        for (int i = 0; i < NV; i++) begin
            step(tbl[i].rst, tbl[i].src, tbl[i].we, tbl[i].clr, tbl[i].mw, tbl[i].ack);
            chk($sformatf("v%0d.mask", i), 32'(rd_data[9:5]), 32'(tbl[i].emask));
            chk($sformatf("v%0d.pend", i), 32'(rd_data[4:0]), 32'(tbl[i].epend));
            chk($sformatf("v%0d.irq", i), 32'(irq), 32'(tbl[i].eirq));
            // irq_vec is only defined while irq=1, and after reset.
            if (tbl[i].eirq || tbl[i].rst)
                chk($sformatf("v%0d.vec", i), 32'(irq_vec), 32'(tbl[i].evec));
        end

        // A level held high sets pending once only; no re-request after ack.
        step(0, 5'h00, 1, 5'h00, 5'h1F, 0);
        chk("hold.mask", 32'(rd_data[9:5]), 32'h1F);
        step(0, 5'h01, 0, 5'h00, 5'h00, 0);
        chk("hold.pend", 32'(rd_data[4:0]), 32'h01);
        step(0, 5'h01, 0, 5'h00, 5'h00, 0);
        chk("hold.irq", 32'(irq), 32'h1);
        chk("hold.vec", 32'(irq_vec), 32'h0);
        step(0, 5'h01, 0, 5'h00, 5'h00, 1);
        chk("hold.ack_irq", 32'(irq), 32'h0);
        for (int k = 0; k < 4; k++) begin
            step(0, 5'h01, 0, 5'h00, 5'h00, 0);
            chk($sformatf("hold.quiet%0d_irq", k), 32'(irq), 32'h0);
            chk($sformatf("hold.quiet%0d_pend", k), 32'(rd_data[4:0]), 32'h00);
        end

        // Latency from src rise to irq, measured with a bounded wait.
        step(0, 5'h08, 0, 5'h00, 5'h00, 0);
        n = 1;
        src = 5'h00;
        while (!irq && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("lat.edges", 32'(n), 32'd2);
        chk("lat.vec", 32'(irq_vec), 32'h3);
        step(0, 5'h00, 0, 5'h00, 5'h00, 1);
        chk("lat.ack_irq", 32'(irq), 32'h0);
        chk("lat.ack_pend", 32'(rd_data[4:0]), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
